// File: rtl/sum_accum_buffer.sv
// Groups N incoming sum samples into one wider total and queues the totals
// in a small first-word-fall-through FIFO for the downstream consumer.
// A flush closes a short group early and marks its result as partial. A
// result that arrives while the FIFO is full, with no pop on the same edge,
// is discarded and counted in a saturating 8-bit drop counter.
module sum_accum_buffer #(
  parameter  int W     = 10,
  parameter  int N     = 4,
  parameter  int DEPTH = 4,
  localparam int SUM_W = W + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             flush,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_data,
  output logic             out_partial,
  input  logic             out_ready,
  output logic [7:0]       drop_cnt
);

  localparam int CNT_W = $clog2(N);
  localparam int AW    = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);

  // Increments a count but holds it once it reaches its maximum.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Open group: running total and number of samples already absorbed.
  logic [SUM_W-1:0] acc_p0;
  logic [CNT_W-1:0] cnt_p0;

  // Group result leaving the accumulator on this edge.
  logic             vld_p0;
  logic [SUM_W-1:0] sum_p0;
  logic             part_p0;

  logic [SUM_W-1:0] sum_in;
  logic             last_smp;

  // FIFO storage: {partial, sum}. The extra pointer bit tells full from empty.
  logic [SUM_W:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             wr_en;
  logic             drop;

  // ---- stage p0: accumulate, decide whether a group result is produced ----

  // Forms the running total with the current sample and picks the group result.
  always_comb begin
    sum_in   = acc_p0 + SUM_W'(in_data);
    last_smp = (cnt_p0 == CNT_LAST);
    vld_p0   = 1'b0;
    sum_p0   = sum_in;
    part_p0  = 1'b0;
    if (in_valid) begin
      // A sample always joins the group; flush only closes it early.
      vld_p0  = last_smp || flush;
      part_p0 = !last_smp;
    end else if (flush && (cnt_p0 != '0)) begin
      vld_p0  = 1'b1;
      sum_p0  = acc_p0;
      part_p0 = 1'b1;
    end
  end

  // Updates the open group; a closed group restarts empty even if its result is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (vld_p0) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (in_valid) begin
      acc_p0 <= sum_in;
      cnt_p0 <= cnt_p0 + CNT_ONE;
    end
  end

  // ---- stage p1: result FIFO ----

  // FIFO occupancy flags and the push/pop/drop decision for this edge.
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = !fifo_empty && out_ready;
    // When full, a same-edge pop frees the head slot that the write reuses.
    wr_en      = vld_p0 && (!fifo_full || pop);
    drop       = vld_p0 && fifo_full && !pop;
  end

  // Writes the new group result into the tail slot.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {part_p0, sum_p0};
    end
  end

  // Advances the read and write pointers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Counts results lost to a full FIFO, holding at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= sat_inc8(drop_cnt);
    end
  end

  // Head of the FIFO is presented directly (first-word-fall-through).
  always_comb begin
    out_valid                 = !fifo_empty;
    {out_partial, out_data}   = mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: tb/tb_sum_accum_buffer.sv
// Bench for sum_accum_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of groups and results.
module tb_sum_accum_buffer;

  localparam int W     = 10;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int SUM_W = W + $clog2(N);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             flush;
  logic             out_valid;
  logic [SUM_W-1:0] out_data;
  logic             out_partial;
  logic             out_ready;
  logic [7:0]       drop_cnt;

  sum_accum_buffer #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_partial(out_partial),
    .out_ready  (out_ready),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: samples of the open group, queued results, drop count.
  typedef struct {
    int data;
    bit part;
  } ent_t;

  int   grp[$];
  ent_t q[$];
  int   m_drop;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Applies one clock edge worth of behaviour to the model.
  task automatic model_step(input bit iv, input int d, input bit fl, input bit rdy, input bit r);
    bit   push;
    bit   do_pop;
    ent_t e;
    int   s;
    push = 1'b0;
    e.data = 0;
    e.part = 1'b0;
    if (r) begin
      grp.delete();
      q.delete();
      m_drop = 0;
      return;
    end
    do_pop = (q.size() != 0) && rdy;
    if (iv) grp.push_back(d);
    if ((iv && (grp.size() == N || fl)) || (!iv && fl && grp.size() > 0)) begin
      s = 0;
      foreach (grp[i]) s += grp[i];
      e.data = s;
      e.part = (grp.size() < N);
      push   = 1'b1;
      grp.delete();
    end
    if (do_pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(e);
      else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(q[0].data));
      check("out_partial", 32'(out_partial), 32'(q[0].part));
    end
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // Drives one cycle of inputs, clocks it, updates the model and compares.
  task automatic cyc(input bit iv, input int d, input bit fl, input bit rdy, input bit r);
    rst       = r;
    in_valid  = iv;
    in_data   = W'(d);
    flush     = fl;
    out_ready = rdy;
    @(posedge clk);
    model_step(iv, d, fl, rdy, r);
    #1;
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    m_drop = 0;

    // Reset, with inputs active during reset to show they are ignored.
    do_reset();
    cyc(1'b1, 7, 1'b1, 1'b1, 1'b1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    idle(1'b1);
    check("rst_idle_valid", 32'(out_valid), 32'd0);

    // 1,2,3,4 -> 10, visible one cycle after the fourth sample.
    cyc(1'b1, 1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 2, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 3, 1'b0, 1'b1, 1'b0);
    check("grp_not_yet", 32'(out_valid), 32'd0);
    cyc(1'b1, 4, 1'b0, 1'b1, 1'b0);
    check("sum10_valid", 32'(out_valid), 32'd1);
    check("sum10_data", 32'(out_data), 32'd10);
    check("sum10_part", 32'(out_partial), 32'd0);
    idle(1'b1);

    // Maximum samples: 4 x 1023 = 4092, no wrap.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1023, 1'b0, 1'b1, 1'b0);
    check("max_data", 32'(out_data), 32'd4092);
    check("max_drop", 32'(drop_cnt), 32'd0);
    idle(1'b1);

    // 5,7 then flush alone -> 12 partial.
    cyc(1'b1, 5, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 7, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    check("flush12_data", 32'(out_data), 32'd12);
    check("flush12_part", 32'(out_partial), 32'd1);
    idle(1'b1);
    // Flush on an empty group does nothing.
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    check("flush_empty_valid", 32'(out_valid), 32'd0);
    // 5 then flush with 9 -> 14 partial.
    cyc(1'b1, 5, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 9, 1'b1, 1'b1, 1'b0);
    check("flush14_data", 32'(out_data), 32'd14);
    check("flush14_part", 32'(out_partial), 32'd1);
    idle(1'b1);
    // Flush together with the N-th sample is a full group.
    for (int i = 0; i < 3; i++) cyc(1'b1, 2, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 2, 1'b1, 1'b1, 1'b0);
    check("flushfull_data", 32'(out_data), 32'd8);
    check("flushfull_part", 32'(out_partial), 32'd0);
    idle(1'b1);

    // Five groups 10..50 with out_ready low: the fifth is dropped.
    do_reset();
    for (int k = 1; k <= 5; k++)
      for (int j = 1; j <= 4; j++) cyc(1'b1, j * k, 1'b0, 1'b0, 1'b0);
    check("full_drop", 32'(drop_cnt), 32'd1);
    check("drain_10", 32'(out_data), 32'd10);
    idle(1'b1);
    check("drain_20", 32'(out_data), 32'd20);
    idle(1'b1);
    check("drain_30", 32'(out_data), 32'd30);
    idle(1'b1);
    check("drain_40", 32'(out_data), 32'd40);
    idle(1'b1);
    check("drain_empty", 32'(out_valid), 32'd0);

    // Full FIFO, group completes on the same edge as a pop: no drop.
    for (int k = 1; k <= 4; k++)
      for (int j = 0; j < 4; j++) cyc(1'b1, k, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) cyc(1'b1, 5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5, 1'b0, 1'b1, 1'b0);
    check("pushpop_drop", 32'(drop_cnt), 32'd1);
    check("pushpop_head", 32'(out_data), 32'd8);
    idle(1'b1);
    check("pushpop_12", 32'(out_data), 32'd12);
    idle(1'b1);
    check("pushpop_16", 32'(out_data), 32'd16);
    idle(1'b1);
    check("pushpop_last", 32'(out_data), 32'd20);
    idle(1'b1);
    check("pushpop_empty", 32'(out_valid), 32'd0);

    // Reset mid-group discards the partial sum.
    do_reset();
    cyc(1'b1, 3, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 3, 1'b0, 1'b1, 1'b0);
    do_reset();
    for (int j = 0; j < 4; j++) cyc(1'b1, 1, 1'b0, 1'b1, 1'b0);
    check("rstmid_data", 32'(out_data), 32'd4);
    check("rstmid_drop", 32'(drop_cnt), 32'd0);
    idle(1'b1);
    check("rstmid_empty", 32'(out_valid), 32'd0);

    // Reset with a non-empty FIFO empties it.
    for (int j = 0; j < 8; j++) cyc(1'b1, 6, 1'b0, 1'b0, 1'b0);
    do_reset();
    check("rstfifo_valid", 32'(out_valid), 32'd0);

    // Drop counter saturates at 255.
    for (int j = 0; j < 262; j++) cyc(1'b1, 1, 1'b1, 1'b0, 1'b0);
    check("drop_sat", 32'(drop_cnt), 32'd255);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
          int'($urandom_range(0, 1023)),
          ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
          ($urandom_range(0, 999) < 5) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
